// File: rtl/flash_read_ctrl.sv
// SPI flash READ (0x03) sequencer: drives CS/SCK/MOSI in mode 0, MSB first, and
// streams the returned bytes out as single-cycle rd_valid pulses.
module flash_read_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              flash_oe,
  output logic              flash_cs,
  output logic              flash_sck,
  output logic              flash_mosi,
  input  logic              flash_miso
);

  localparam int OUT_W = 8 + ADDR_W;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(OUT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] OUT_LAST = BIT_W'(OUT_W - 1);
  localparam logic [BIT_W-1:0] IN_LAST  = BIT_W'(7);
  localparam logic [7:0]       CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_OUT,
    SHIFT_IN,
    HOLD,
    GAP
  } state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [OUT_W-1:0]   out_sr, out_sr_nxt;
  logic [7:0]         in_sr, in_sr_nxt;
  logic [LEN_W-1:0]   remaining, remaining_nxt;
  logic               busy_nxt, done_nxt, rd_valid_nxt;
  logic [7:0]         rd_data_nxt;
  logic               oe_nxt, cs_nxt, sck_nxt, mosi_nxt;
  logic               div_end;

  // State and every output are registered together so the pins never glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      out_sr     <= '0;
      in_sr      <= '0;
      remaining  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      flash_oe   <= 1'b0;
      flash_cs   <= 1'b1;
      flash_sck  <= 1'b0;
      flash_mosi <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      out_sr     <= out_sr_nxt;
      in_sr      <= in_sr_nxt;
      remaining  <= remaining_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      rd_data    <= rd_data_nxt;
      rd_valid   <= rd_valid_nxt;
      flash_oe   <= oe_nxt;
      flash_cs   <= cs_nxt;
      flash_sck  <= sck_nxt;
      flash_mosi <= mosi_nxt;
    end
  end

  assign div_end = (div_cnt == DIV_LAST);

  // Each SCK half-period lasts CLK_DIV clocks; div_end marks the clock on which
  // SCK toggles (or a timed SETUP/HOLD/GAP phase ends).
  always_comb begin
    state_nxt     = state;
    div_cnt_nxt   = div_cnt;
    bit_cnt_nxt   = bit_cnt;
    out_sr_nxt    = out_sr;
    in_sr_nxt     = in_sr;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    rd_valid_nxt  = 1'b0;
    rd_data_nxt   = rd_data;
    cs_nxt        = flash_cs;
    sck_nxt       = flash_sck;
    mosi_nxt      = flash_mosi;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (len != '0) begin
            state_nxt     = SETUP;
            out_sr_nxt    = {CMD_READ, addr};
            remaining_nxt = len;
            div_cnt_nxt   = '0;
            bit_cnt_nxt   = '0;
            cs_nxt        = 1'b0;
            sck_nxt       = 1'b0;
            mosi_nxt      = CMD_READ[7];
          end else begin
            done_nxt = 1'b1;
          end
        end
      end

      SETUP: begin
        if (div_end) begin
          state_nxt   = SHIFT_OUT;
          div_cnt_nxt = '0;
          sck_nxt     = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      SHIFT_OUT: begin
        if (!div_end) begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end else begin
          div_cnt_nxt = '0;
          sck_nxt     = !flash_sck;
          // MOSI only moves on the falling edge so it is stable at the rise.
          if (flash_sck) begin
            if (bit_cnt == OUT_LAST) begin
              state_nxt   = SHIFT_IN;
              bit_cnt_nxt = '0;
              mosi_nxt    = 1'b0;
            end else begin
              bit_cnt_nxt = bit_cnt + BIT_W'(1);
              out_sr_nxt  = out_sr << 1;
              mosi_nxt    = out_sr[OUT_W-2];
            end
          end
        end
      end

      SHIFT_IN: begin
        if (!div_end) begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end else begin
          div_cnt_nxt = '0;
          sck_nxt     = !flash_sck;
          if (flash_sck) begin
            if (remaining == '0) begin
              state_nxt = HOLD;
            end
          end else begin
            in_sr_nxt = {in_sr[6:0], flash_miso};
            if (bit_cnt == IN_LAST) begin
              bit_cnt_nxt   = '0;
              rd_valid_nxt  = 1'b1;
              rd_data_nxt   = {in_sr[6:0], flash_miso};
              remaining_nxt = remaining - LEN_W'(1);
            end else begin
              bit_cnt_nxt = bit_cnt + BIT_W'(1);
            end
          end
        end
      end

      HOLD: begin
        if (div_end) begin
          state_nxt   = GAP;
          div_cnt_nxt = '0;
          cs_nxt      = 1'b1;
          done_nxt    = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      GAP: begin
        if (div_end) begin
          state_nxt   = IDLE;
          div_cnt_nxt = '0;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      default: begin
        state_nxt   = IDLE;
        div_cnt_nxt = '0;
        cs_nxt      = 1'b1;
        sck_nxt     = 1'b0;
        mosi_nxt    = 1'b0;
      end
    endcase

    // Abort wins over everything: partial byte dropped, no done; GAP is already deselecting.
    if (abort && (state != IDLE) && (state != GAP)) begin
      state_nxt    = GAP;
      div_cnt_nxt  = '0;
      bit_cnt_nxt  = '0;
      cs_nxt       = 1'b1;
      sck_nxt      = 1'b0;
      mosi_nxt     = 1'b0;
      done_nxt     = 1'b0;
      rd_valid_nxt = 1'b0;
      rd_data_nxt  = rd_data;
    end

    busy_nxt = (state_nxt != IDLE);
    oe_nxt   = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Directed bench for flash_read_ctrl: a CLK_DIV=2 instance carries the main, len=0,
// busy-start, abort and reset cases; a CLK_DIV=1 instance checks the fast timing.
module tb_flash_read_ctrl;

  logic clock;
  logic reset_n;

  logic        start_a, abort_a;
  logic [23:0] addr_a;
  logic [15:0] len_a;
  logic        busy_a, done_a, rd_valid_a, oe_a, cs_a, sck_a, mosi_a, miso_a;
  logic [7:0]  rd_data_a;

  logic        start_b, abort_b;
  logic [23:0] addr_b;
  logic [15:0] len_b;
  logic        busy_b, done_b, rd_valid_b, oe_b, cs_b, sck_b, mosi_b, miso_b;
  logic [7:0]  rd_data_b;

  int assert_count = 0;
  int fail_count   = 0;

  logic [7:0] data_a [8] = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] data_b [8] = '{8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  int          rises_a = 0;
  int          rises_b = 0;
  logic [31:0] mosi_cap_a = '0;
  time         last_rise_b = 0;
  time         rise_period_b = 0;
  int          cyc = 0;
  int          done_cnt_a = 0;
  int          done_cnt_b = 0;
  int          last_rv_b = 0;
  int          rv_gap_b = 0;
  logic [7:0]  rdq_a [$];
  logic [7:0]  rdq_b [$];

  int rd_before, done_before;

  flash_read_ctrl #(.CLK_DIV(2), .ADDR_W(24), .LEN_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .addr(addr_a), .len(len_a),
    .abort(abort_a), .busy(busy_a), .done(done_a), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .flash_oe(oe_a), .flash_cs(cs_a), .flash_sck(sck_a),
    .flash_mosi(mosi_a), .flash_miso(miso_a)
  );

  flash_read_ctrl #(.CLK_DIV(1), .ADDR_W(24), .LEN_W(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .addr(addr_b), .len(len_b),
    .abort(abort_b), .busy(busy_b), .done(done_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .flash_oe(oe_b), .flash_cs(cs_b), .flash_sck(sck_b),
    .flash_mosi(mosi_b), .flash_miso(miso_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Flash model A: counts SCK rises per CS assertion, captures command/address bits,
  // and presents data bits after each falling edge once the header has gone out.
  always @(posedge sck_a or negedge cs_a) begin
    if (sck_a) begin
      if (rises_a < 32) mosi_cap_a = {mosi_cap_a[30:0], mosi_a};
      rises_a = rises_a + 1;
    end else begin
      rises_a    = 0;
      mosi_cap_a = '0;
    end
  end

  always @(negedge sck_a or negedge cs_a) begin
    if (!cs_a && rises_a >= 32) begin
      miso_a = data_a[((rises_a - 32) >> 3) & 7][7 - ((rises_a - 32) & 7)];
    end else begin
      miso_a = 1'b0;
    end
  end

  always @(posedge sck_b or negedge cs_b) begin
    if (sck_b) begin
      rises_b       = rises_b + 1;
      rise_period_b = $time - last_rise_b;
      last_rise_b   = $time;
    end else begin
      rises_b = 0;
    end
  end

  always @(negedge sck_b or negedge cs_b) begin
    if (!cs_b && rises_b >= 32) begin
      miso_b = data_b[((rises_b - 32) >> 3) & 7][7 - ((rises_b - 32) & 7)];
    end else begin
      miso_b = 1'b0;
    end
  end

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (rd_valid_a) rdq_a.push_back(rd_data_a);
    if (rd_valid_b) begin
      rdq_b.push_back(rd_data_b);
      rv_gap_b  = cyc - last_rv_b;
      last_rv_b = cyc;
    end
    if (done_a) done_cnt_a = done_cnt_a + 1;
    if (done_b) done_cnt_b = done_cnt_b + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [23:0] a, input logic [15:0] l);
    start_a = 1'b1;
    addr_a  = a;
    len_a   = l;
    @(negedge clock);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 3000 && done_a !== 1'b1; i++) @(negedge clock);
  endtask

  task automatic wait_done_b();
    for (int i = 0; i < 3000 && done_b !== 1'b1; i++) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; addr_a = '0; len_a = '0;
    start_b = 1'b0; abort_b = 1'b0; addr_b = '0; len_b = '0;
    repeat (2) @(negedge clock);

    // Reset values: {busy,done,rd_valid,oe,cs,sck,mosi}
    check_output("reset_pins", 32'({busy_a, done_a, rd_valid_a, oe_a, cs_a, sck_a, mosi_a}),
                 32'b0000100);
    check_output("reset_rd_data", 32'(rd_data_a), 32'h00);
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] basic read addr=012345 len=3");
    rd_before = rdq_a.size(); done_before = done_cnt_a;
    apply_stimulus(24'h012345, 16'd3);
    check_output("t1_first_cycle", 32'({busy_a, oe_a, cs_a, mosi_a}), 32'b1100);
    repeat (40) @(negedge clock);
    apply_stimulus(24'h000000, 16'd5);
    check_output("t1_busy_mid", 32'(busy_a), 32'h1);
    wait_done_a();
    check_output("t1_done_seen", 32'(done_a), 32'h1);
    check_output("t1_cs_sck_at_done", 32'({cs_a, sck_a, busy_a}), 32'b101);
    @(negedge clock);
    check_output("t1_busy_gap1", 32'({busy_a, done_a}), 32'b10);
    @(negedge clock);
    check_output("t1_busy_oe_idle", 32'({busy_a, oe_a, cs_a}), 32'b001);
    check_output("t1_mosi_header", mosi_cap_a, 32'h03012345);
    check_output("t1_sck_rises", 32'(rises_a), 32'd56);
    check_output("t1_rd_count", 32'(rdq_a.size() - rd_before), 32'd3);
    if (rdq_a.size() >= rd_before + 3) begin
      check_output("t1_byte0", 32'(rdq_a[rd_before]), 32'hA5);
      check_output("t1_byte1", 32'(rdq_a[rd_before + 1]), 32'h5A);
      check_output("t1_byte2", 32'(rdq_a[rd_before + 2]), 32'hFF);
    end
    check_output("t1_done_count", 32'(done_cnt_a - done_before), 32'd1);

    $display("[TB] zero-length start");
    start_a = 1'b1; addr_a = 24'h000010; len_a = 16'd0;
    @(negedge clock);
    start_a = 1'b0;
    check_output("t2_done_pulse", 32'({done_a, busy_a, oe_a, cs_a}), 32'b1001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_output("t2_pins_quiet", 32'({done_a, busy_a, oe_a, cs_a}), 32'b0001);
    end

    $display("[TB] abort after 12 SCK rises");
    rd_before = rdq_a.size(); done_before = done_cnt_a;
    apply_stimulus(24'h0ABCDE, 16'd2);
    for (int i = 0; i < 500 && rises_a < 12; i++) @(negedge clock);
    check_output("t3_reached_12", 32'(rises_a), 32'd12);
    abort_a = 1'b1;
    @(negedge clock);
    abort_a = 1'b0;
    check_output("t3_abort_pins", 32'({cs_a, sck_a, mosi_a, busy_a}), 32'b1001);
    for (int i = 0; i < 20 && busy_a !== 1'b0; i++) @(negedge clock);
    check_output("t3_idle_after_gap", 32'({busy_a, oe_a, cs_a}), 32'b001);
    check_output("t3_no_done", 32'(done_cnt_a - done_before), 32'd0);
    check_output("t3_no_rd_valid", 32'(rdq_a.size() - rd_before), 32'd0);

    $display("[TB] reset during SHIFT_IN");
    done_before = done_cnt_a;
    apply_stimulus(24'h000100, 16'd4);
    for (int i = 0; i < 500 && rises_a < 36; i++) @(negedge clock);
    check_output("t4_reached_36", 32'(rises_a), 32'd36);
    #2 reset_n = 1'b0;
    #1 check_output("t4_async_reset", 32'({cs_a, oe_a, busy_a, sck_a}), 32'b1000);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_output("t4_no_done", 32'(done_cnt_a - done_before), 32'd0);
    rd_before = rdq_a.size();
    apply_stimulus(24'h000200, 16'd1);
    wait_done_a();
    check_output("t4_restart_done", 32'(done_a), 32'h1);
    check_output("t4_restart_rd_count", 32'(rdq_a.size() - rd_before), 32'd1);
    if (rdq_a.size() > rd_before) check_output("t4_restart_byte", 32'(rdq_a[rd_before]), 32'hA5);
    repeat (4) @(negedge clock);

    $display("[TB] CLK_DIV=1 timing");
    rd_before = rdq_b.size();
    start_b = 1'b1; addr_b = 24'h00FF00; len_b = 16'd1;
    @(negedge clock);
    start_b = 1'b0;
    wait_done_b();
    check_output("t5_done", 32'(done_b), 32'h1);
    check_output("t5_sck_rises", 32'(rises_b), 32'd40);
    check_output("t5_sck_period", 32'(rise_period_b), 32'd20);
    if (rdq_b.size() > rd_before) check_output("t5_byte0", 32'(rdq_b[rd_before]), 32'hC3);
    repeat (4) @(negedge clock);
    rd_before = rdq_b.size();
    start_b = 1'b1; addr_b = 24'h00FF00; len_b = 16'd2;
    @(negedge clock);
    start_b = 1'b0;
    wait_done_b();
    check_output("t5b_sck_rises", 32'(rises_b), 32'd48);
    check_output("t5b_rd_count", 32'(rdq_b.size() - rd_before), 32'd2);
    check_output("t5b_byte_spacing", 32'(rv_gap_b), 32'd16);
    if (rdq_b.size() >= rd_before + 2) check_output("t5b_byte1", 32'(rdq_b[rd_before + 1]), 32'h3C);
    repeat (4) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
